mdu_ctrl: RTL and testbench
===========================

# mdu_ctrl

Multi-cycle multiply/divide sequencer that owns the HI/LO register pair and drives the `busy` flag consumed by the stall logic in stage D. It accepts one operation per issue from stage E. It sequences mult/div through a fixed-latency countdown, commits results to HI/LO on completion, and handles direct HI/LO writes. Exception requests can suppress an issue in the same cycle.

## Interface
- `MULT_CYCLES`, default 5: cycles from mult/multu issue to HI/LO commit. Legal range 1..15.
- `DIV_CYCLES`, default 10: cycles from div/divu issue to HI/LO commit. Legal range 1..15.
- `clk` input 1: single clock, rising edge.
- `reset` input 1: asynchronous, active-high; clears all state.
- `start` input 1: issue strobe for `op` this cycle.
- `op` input 3: 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo. 0 and 7 are no-ops.
- `A` input 32: rs operand, already forwarded.
- `B` input 32: rt operand, already forwarded.
- `req` input 1: exception/interrupt taken this cycle; cancels the current issue.
- `busy` output 1: registered; high while an arithmetic op is in flight.
- `done` output 1: registered one-cycle pulse in the cycle after the HI/LO commit edge.
- `hi` output 32: current HI register, direct register output.
- `lo` output 32: current LO register, direct register output.

## Operation
- States: IDLE, RUN. A 4-bit down-counter `cnt` and 64-bit pending result register `res` are used.
- Issue is accepted when `start && !req` in IDLE.
  - mult/multu/div/divu: compute the result into `res` at the issue edge, load `cnt` with N-1 (N = MULT_CYCLES or DIV_CYCLES), and go to RUN.
  - mthi: HI <= A at the issue edge; stay in IDLE.
  - mtlo: LO <= A at the issue edge; stay in IDLE.
  - No-op codes: no state change.
- RUN:
  - When `cnt != 0`: decrement `cnt`.
  - When `cnt == 0`: {HI,LO} <= `res`, pulse `done`, return to IDLE.
- `start` while in RUN is ignored entirely. The stall logic guarantees this never happens; assert it in simulation.
- `req` during RUN does not abort; the in-flight op completes and commits normally.
- Arithmetic:
  - mult: signed 32x32 -> 64; HI = [63:32], LO = [31:0].
  - multu: unsigned 32x32 -> 64; HI = [63:32], LO = [31:0].
  - div/divu: LO = quotient, HI = remainder. Signed division truncates toward zero; the remainder takes the sign of the dividend.
  - Divide by zero (div or divu): LO = 32'hFFFF_FFFF, HI = A.
  - Signed overflow (A = 32'h8000_0000, B = 32'hFFFF_FFFF, div): LO = 32'h8000_0000, HI = 0.
- `hi` and `lo` never change except at a commit edge or an mthi/mtlo edge.

## Timing
- Reset values: state IDLE, `busy` 0, `done` 0, `hi` 0, `lo` 0, `cnt` 0, `res` 0.
- Reset asserted mid-RUN aborts the operation: no commit and no `done` pulse.
- Issue sampled at edge t0. `busy` is 1 for cycles t0+1 .. t0+N, i.e. exactly N cycles.
- HI/LO update at edge t0+N. `busy` falls and `done` is 1 during cycle t0+N+1 only.
- `busy` is registered, so it is 0 in the issue cycle itself. The stall unit must use `busy | (start && op in 1..4)`.
- Back-to-back: a new issue is accepted at edge t0+N+1 at the earliest, i.e. the first cycle `busy` is 0.
- mthi/mtlo take effect at the issue edge; `hi`/`lo` show the new value in the next cycle. `busy` is never set for them.
- `start && req` in the same cycle: nothing changes. `busy`, `hi` and `lo` are unchanged.

## Test plan
- mult, A=32'hFFFF_FFFD (-3), B=5 -> `busy` high for exactly 5 cycles, then hi=32'hFFFF_FFFF, lo=32'hFFFF_FFF1, with a single `done` pulse.
- divu, A=100, B=7 -> `busy` high for 10 cycles, then lo=14, hi=2. A div with A=-7, B=2 -> lo=32'hFFFF_FFFD, hi=32'hFFFF_FFFF.
- Boundary divides:
  - div, A=32'h8000_0000, B=-1 -> lo=32'h8000_0000, hi=0.
  - divu, A=123, B=0 -> lo=32'hFFFF_FFFF, hi=123.
- mthi A=32'hDEAD_BEEF, then mtlo A=1 on consecutive cycles -> hi=32'hDEAD_BEEF and lo=1 one cycle after each issue; `busy` stays 0.
- mult issued with `req`=1 in the same cycle -> `busy` stays 0 and hi/lo are unchanged. `req`=1 pulsed mid-RUN of a multu with A=B=32'hFFFF_FFFF -> still commits hi=32'hFFFF_FFFE, lo=1.
- Start div (A=9, B=3), then assert `reset` in cycle t0+4 -> `busy`, hi and lo read 0 immediately (asynchronous); no `done` pulse. After reset release, a mult with A=2, B=3 completes normally with lo=6.

Source files
------------

// File: rtl/mdu_ctrl.sv
// Multiply/divide sequencer owning the HI/LO pair: issues arithmetic ops into a
// fixed-latency countdown, commits results on completion, handles mthi/mtlo.
module mdu_ctrl #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        req,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int unsigned CW = 4;
  localparam int unsigned DW = 32;
  localparam int unsigned RW = 2 * DW;

  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;

  localparam logic [CW-1:0] MULT_LOAD = CW'(MULT_CYCLES - 1);
  localparam logic [CW-1:0] DIV_LOAD  = CW'(DIV_CYCLES - 1);

  typedef enum logic {S_IDLE, S_RUN} state_t;

  state_t         r_state;
  state_t         w_state_nxt;
  logic [CW-1:0]  r_cnt;
  logic [RW-1:0]  r_res;
  logic           r_busy;
  logic           r_done;
  logic [DW-1:0]  r_hi;
  logic [DW-1:0]  r_lo;

  logic           w_issue;
  logic           w_arith;
  logic           w_mthi;
  logic           w_mtlo;
  logic           w_commit;
  logic [CW-1:0]  w_cnt_load;
  logic [RW-1:0]  w_result;

  logic signed [DW-1:0] w_sa;
  logic signed [DW-1:0] w_sb;
  logic signed [DW-1:0] w_sdiv_b;
  logic signed [DW-1:0] w_sq;
  logic signed [DW-1:0] w_sr;
  logic signed [RW-1:0] w_prod_s;
  logic [RW-1:0]        w_prod_u;
  logic [DW-1:0]        w_udiv_b;
  logic [DW-1:0]        w_uq;
  logic [DW-1:0]        w_ur;
  logic                 w_div_zero;
  logic                 w_div_ovf;

  // Arithmetic datapath; divisor is forced to 1 on the special cases so the
  // divider never sees /0 or INT_MIN/-1, and those results are muxed in below.
  always_comb begin
    w_sa       = A;
    w_sb       = B;
    w_div_zero = (B == '0);
    w_div_ovf  = (A == 32'h8000_0000) && (B == 32'hFFFF_FFFF);
    w_sdiv_b   = (w_div_zero || w_div_ovf) ? 32'sd1 : w_sb;
    w_udiv_b   = w_div_zero ? 32'd1 : B;
    w_prod_s   = RW'(w_sa) * RW'(w_sb);
    w_prod_u   = RW'(A) * RW'(B);
    w_sq       = w_sa / w_sdiv_b;
    w_sr       = w_sa % w_sdiv_b;
    w_uq       = A / w_udiv_b;
    w_ur       = A % w_udiv_b;
    w_result   = '0;
    case (op)
      OP_MULT:  w_result = w_prod_s;
      OP_MULTU: w_result = w_prod_u;
      OP_DIV: begin
        if (w_div_zero)     w_result = {A, 32'hFFFF_FFFF};
        else if (w_div_ovf) w_result = {32'h0000_0000, 32'h8000_0000};
        else                w_result = {w_sr, w_sq};
      end
      OP_DIVU: begin
        if (w_div_zero) w_result = {A, 32'hFFFF_FFFF};
        else            w_result = {w_ur, w_uq};
      end
      default: w_result = '0;
    endcase
  end

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_arith)  w_state_nxt = S_RUN;
      S_RUN:   if (w_commit) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Control decode; start is only honoured in IDLE and only without req
  always_comb begin
    w_issue    = (r_state == S_IDLE) && start && !req;
    w_arith    = w_issue && (op inside {OP_MULT, OP_MULTU, OP_DIV, OP_DIVU});
    w_mthi     = w_issue && (op == OP_MTHI);
    w_mtlo     = w_issue && (op == OP_MTLO);
    w_commit   = (r_state == S_RUN) && (r_cnt == '0);
    w_cnt_load = ((op == OP_MULT) || (op == OP_MULTU)) ? MULT_LOAD : DIV_LOAD;
  end

  // Countdown, pending result, HI/LO and registered status flags
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt  <= '0;
      r_res  <= '0;
      r_busy <= 1'b0;
      r_done <= 1'b0;
      r_hi   <= '0;
      r_lo   <= '0;
    end else begin
      r_busy <= (w_state_nxt == S_RUN);
      r_done <= w_commit;
      if (w_arith) begin
        r_res <= w_result;
        r_cnt <= w_cnt_load;
      end else if ((r_state == S_RUN) && (r_cnt != '0)) begin
        r_cnt <= r_cnt - CW'(1);
      end
      if (w_commit) begin
        r_hi <= r_res[RW-1:DW];
        r_lo <= r_res[DW-1:0];
      end
      if (w_mthi) r_hi <= A;
      if (w_mtlo) r_lo <= A;
    end
  end

  assign busy = r_busy;
  assign done = r_done;
  assign hi   = r_hi;
  assign lo   = r_lo;

  // Stall logic must keep issues away while an op is in flight
  a_no_start_in_run: assert property (@(posedge clk) disable iff (reset)
    (r_state == S_RUN) |-> !start)
    else $error("mdu_ctrl: start asserted while busy");

endmodule

// File: tb/tb_mdu_ctrl.sv
// Directed bench for mdu_ctrl: a cycle-level behavioural model checked every
// cycle, plus literal expectations for the hand-computed vectors.
module tb_mdu_ctrl;

  localparam int unsigned MC = 5;
  localparam int unsigned DC = 10;

  logic        clk   = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        req   = 1'b0;
  logic [2:0]  op    = 3'd0;
  logic [31:0] A     = '0;
  logic [31:0] B     = '0;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  mdu_ctrl #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .A(A), .B(B),
    .req(req), .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference result from the architectural rules
  function automatic logic [63:0] calc(input logic [2:0] o, input logic [31:0] a,
                                       input logic [31:0] b);
    int            ia, ib;
    longint        la, lb, q, r;
    longint unsigned ua, ub;
    logic [63:0]   qv, rv;
    ia = a; ib = b;
    la = ia; lb = ib;
    ua = a;  ub = b;
    case (o)
      3'd1: return la * lb;
      3'd2: return ua * ub;
      3'd3: begin
        if (b == 0) return {a, 32'hFFFF_FFFF};
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'h0, 32'h8000_0000};
        q = la / lb; r = la % lb;
        qv = q; rv = r;
        return {rv[31:0], qv[31:0]};
      end
      3'd4: begin
        if (b == 0) return {a, 32'hFFFF_FFFF};
        return {a % b, a / b};
      end
      default: return 64'd0;
    endcase
  endfunction

  // Model: an issued op stays busy for N edges and commits on the Nth
  int          m_left = 0;
  logic        m_done = 1'b0;
  logic [31:0] m_hi   = '0;
  logic [31:0] m_lo   = '0;
  logic [63:0] m_res  = '0;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_left <= 0;
      m_done <= 1'b0;
      m_hi   <= '0;
      m_lo   <= '0;
      m_res  <= '0;
    end else if (m_left != 0) begin
      m_left <= m_left - 1;
      m_done <= (m_left == 1);
      if (m_left == 1) begin
        m_hi <= m_res[63:32];
        m_lo <= m_res[31:0];
      end
    end else begin
      m_done <= 1'b0;
      if (start && !req) begin
        if (op >= 3'd1 && op <= 3'd4) begin
          m_res  <= calc(op, A, B);
          m_left <= (op <= 3'd2) ? int'(MC) : int'(DC);
        end else if (op == 3'd5) begin
          m_hi <= A;
        end else if (op == 3'd6) begin
          m_lo <= A;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (!reset) begin
      chk("busy", 64'(busy), 64'(m_left != 0));
      chk("done", 64'(done), 64'(m_done));
      chk("hi",   64'(hi),   64'(m_hi));
      chk("lo",   64'(lo),   64'(m_lo));
    end
  end

  task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                       input logic rq);
    start = 1'b1; op = o; A = a; B = b; req = rq;
    @(posedge clk); #2;
    start = 1'b0; req = 1'b0; op = 3'd0;
  endtask

  task automatic wait_done(output int bc, output int dc);
    bc = 0; dc = 0;
    for (int i = 0; i < 40; i++) begin
      if (busy) bc++;
      if (done) begin
        dc = 1;
        break;
      end
      @(posedge clk); #2;
    end
  endtask

  task automatic run(input string name, input logic [2:0] o, input logic [31:0] a,
                     input logic [31:0] b, input int n, input logic [31:0] eh,
                     input logic [31:0] el);
    int bc, dc;
    issue(o, a, b, 1'b0);
    wait_done(bc, dc);
    chk({name, "_busy_cycles"}, 64'(bc), 64'(n));
    chk({name, "_done"}, 64'(dc), 64'd1);
    chk({name, "_hi"}, 64'(hi), 64'(eh));
    chk({name, "_lo"}, 64'(lo), 64'(el));
  endtask

  initial begin
    int bc, dc;
    repeat (3) @(posedge clk);
    #2 reset = 1'b0;
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_hi",   64'(hi),   64'd0);
    chk("rst_lo",   64'(lo),   64'd0);
    @(posedge clk); #2;

    run("mult_m3x5", 3'd1, 32'hFFFF_FFFD, 32'd5, MC, 32'hFFFF_FFFF, 32'hFFFF_FFF1);
    run("divu_100_7", 3'd4, 32'd100, 32'd7, DC, 32'd2, 32'd14);
    run("div_m7_2", 3'd3, 32'hFFFF_FFF9, 32'd2, DC, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run("div_ovf", 3'd3, 32'h8000_0000, 32'hFFFF_FFFF, DC, 32'h0, 32'h8000_0000);
    run("divu_by0", 3'd4, 32'd123, 32'd0, DC, 32'd123, 32'hFFFF_FFFF);
    run("div_by0", 3'd3, 32'hFFFF_FFFB, 32'd0, DC, 32'hFFFF_FFFB, 32'hFFFF_FFFF);
    run("mult_big", 3'd1, 32'h7FFF_FFFF, 32'h8000_0000, MC, 32'hC000_0000, 32'h8000_0000);

    issue(3'd5, 32'hDEAD_BEEF, 32'd0, 1'b0);
    chk("mthi_hi", 64'(hi), 64'h0000_0000_DEAD_BEEF);
    chk("mthi_busy", 64'(busy), 64'd0);
    issue(3'd6, 32'd1, 32'd0, 1'b0);
    chk("mtlo_lo", 64'(lo), 64'd1);
    chk("mtlo_hi", 64'(hi), 64'h0000_0000_DEAD_BEEF);
    chk("mtlo_busy", 64'(busy), 64'd0);

    issue(3'd1, 32'd2, 32'd3, 1'b1);
    chk("req_busy", 64'(busy), 64'd0);
    chk("req_hi", 64'(hi), 64'h0000_0000_DEAD_BEEF);
    chk("req_lo", 64'(lo), 64'd1);
    issue(3'd7, 32'd9, 32'd9, 1'b0);
    chk("nop_busy", 64'(busy), 64'd0);

    issue(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    @(posedge clk); #2;
    req = 1'b1;
    @(posedge clk); #2;
    req = 1'b0;
    wait_done(bc, dc);
    chk("multu_req_busy_cycles", 64'(bc), 64'(MC - 2));
    chk("multu_req_done", 64'(dc), 64'd1);
    chk("multu_req_hi", 64'(hi), 64'h0000_0000_FFFF_FFFE);
    chk("multu_req_lo", 64'(lo), 64'd1);

    issue(3'd3, 32'd9, 32'd3, 1'b0);
    repeat (3) begin
      @(posedge clk); #2;
    end
    reset = 1'b1;
    #1;
    chk("arst_busy", 64'(busy), 64'd0);
    chk("arst_hi",   64'(hi),   64'd0);
    chk("arst_lo",   64'(lo),   64'd0);
    @(posedge clk); #2;
    reset = 1'b0;
    dc = 0;
    repeat (12) begin
      if (done) dc++;
      @(posedge clk); #2;
    end
    chk("arst_no_done", 64'(dc), 64'd0);
    run("mult_2x3", 3'd1, 32'd2, 32'd3, MC, 32'd0, 32'd6);

    repeat (3) @(posedge clk);
    #2;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
